// File: rtl/fp_add_sub.sv
// Pipelined IEEE-754 style adder/subtractor with round-to-nearest-even.
// Stages: order operands, align and add, normalise/round/pack; one shared stall from output backpressure.
module fp_add_sub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FTZ   = 1,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         sub_i,
  output logic [W-1:0] result_o,
  output logic         done_o,
  input  logic         ready_i,
  output logic         overflow_o,
  output logic         underflow_o,
  output logic         invalid_o,
  output logic         inexact_o
);
  localparam int SW = MAN_W + 1;
  localparam int XW = MAN_W + 4;
  localparam int CW = 16;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  logic v1_q, v2_q, done_q;
  logic [W-1:0] res_q;
  logic ovf_q, unf_q, inv_q, inx_q;

  assign en          = !(done_q && !ready_i);
  assign ready_o     = en;
  assign done_o      = done_q;
  assign result_o    = res_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign invalid_o   = inv_q;
  assign inexact_o   = inx_q;

  // Stage 1: subnormals count as exponent 1 with no hidden bit; flushed ones become plain zero.
  logic             sgnA, sgnB, nanA, nanB, infA, infB, swap;
  logic [W-2:0]     magA, magB, magL, magS;
  logic [EXP_W-1:0] expS;
  logic             sgn1_d, eff1_d, zs1_d, spec1_d, nan1_d;
  logic [EXP_W-1:0] exp1_d, dif1_d;
  logic [SW-1:0]    sigL1_d, sigS1_d;
  logic [W-1:0]     specRes1_d;

  always_comb begin
    sgnA    = A[W-1];
    sgnB    = B[W-1] ^ sub_i;
    nanA    = (A[W-2:MAN_W] == EXP_ONES) && (A[MAN_W-1:0] != '0);
    nanB    = (B[W-2:MAN_W] == EXP_ONES) && (B[MAN_W-1:0] != '0);
    infA    = (A[W-2:MAN_W] == EXP_ONES) && (A[MAN_W-1:0] == '0);
    infB    = (B[W-2:MAN_W] == EXP_ONES) && (B[MAN_W-1:0] == '0);
    magA    = (FTZ != 0 && A[W-2:MAN_W] == '0) ? '0 : A[W-2:0];
    magB    = (FTZ != 0 && B[W-2:MAN_W] == '0) ? '0 : B[W-2:0];
    swap    = magB > magA;
    magL    = swap ? magB : magA;
    magS    = swap ? magA : magB;
    sgn1_d  = swap ? sgnB : sgnA;
    eff1_d  = sgnA ^ sgnB;
    zs1_d   = sgnA & sgnB;
    exp1_d  = (magL[W-2:MAN_W] == '0) ? EXP_W'(1) : magL[W-2:MAN_W];
    expS    = (magS[W-2:MAN_W] == '0) ? EXP_W'(1) : magS[W-2:MAN_W];
    dif1_d  = exp1_d - expS;
    sigL1_d = {magL[W-2:MAN_W] != '0, magL[MAN_W-1:0]};
    sigS1_d = {magS[W-2:MAN_W] != '0, magS[MAN_W-1:0]};
    nan1_d  = nanA | nanB | (infA & infB & eff1_d);
    spec1_d = nan1_d | infA | infB;
    specRes1_d = nan1_d ? QNAN : {(infA ? sgnA : sgnB), EXP_ONES, {MAN_W{1'b0}}};
  end

  logic             sgn1_q, eff1_q, zs1_q, spec1_q, nan1_q;
  logic [EXP_W-1:0] exp1_q, dif1_q;
  logic [SW-1:0]    sigL1_q, sigS1_q;
  logic [W-1:0]     specRes1_q;

  // Stage 2: guard/round/sticky alignment keeps the rounded result equal to rounding the exact sum.
  logic [XW-1:0] ext2, shf2, aln2;
  logic [XW:0]   sum2_d;

  always_comb begin
    ext2    = {sigS1_q, 3'b000};
    shf2    = ext2 >> dif1_q;
    aln2    = shf2;
    aln2[0] = shf2[0] | ((shf2 << dif1_q) != ext2);
    if (eff1_q) sum2_d = {1'b0, sigL1_q, 3'b000} - {1'b0, aln2};
    else        sum2_d = {1'b0, sigL1_q, 3'b000} + {1'b0, aln2};
  end

  logic             sgn2_q, zs2_q, spec2_q, nan2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [XW:0]      sum2_q;
  logic [W-1:0]     specRes2_q;

  // Stage 3: a tiny result stops its left shift at exponent 1, and a rounding carry ripples into the exponent.
  logic [CW-1:0]          lz, sh;
  logic                   carry, tiny, g, rest, rnd;
  logic [XW-1:0]          nrm;
  logic [EXP_W-1:0]       expF;
  logic [EXP_W+MAN_W:0]   rounded;
  logic [W-1:0]           res_d;
  logic                   ovf_d, unf_d, inv_d, inx_d;

  always_comb begin
    lz = CW'(XW);
    for (int i = 0; i < XW; i++) if (sum2_q[i]) lz = CW'(XW - 1 - i);
    sh    = '0;
    carry = sum2_q[XW];
    tiny  = 1'b0;
    nrm   = sum2_q[XW-1:0];
    expF  = '0;
    if (carry) begin
      nrm  = {sum2_q[XW:2], sum2_q[1] | sum2_q[0]};
      expF = exp2_q + EXP_W'(1);
    end else begin
      tiny = lz >= CW'(exp2_q);
      sh   = tiny ? CW'(exp2_q) - CW'(1) : lz;
      nrm  = sum2_q[XW-1:0] << sh;
      expF = tiny ? {{(EXP_W-1){1'b0}}, nrm[XW-1]} : exp2_q - EXP_W'(lz);
    end
    g       = nrm[2];
    rest    = nrm[1] | nrm[0];
    rnd     = g & (rest | nrm[3]);
    rounded = {1'b0, expF, nrm[XW-2:3]} + (EXP_W+MAN_W+1)'(rnd);
    res_d   = '0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    inv_d   = 1'b0;
    inx_d   = 1'b0;
    if (spec2_q) begin
      res_d = specRes2_q;
      inv_d = nan2_q;
    end else if (sum2_q == '0) begin
      res_d = {zs2_q, {(W-1){1'b0}}};
    end else if (tiny && FTZ != 0) begin
      res_d = {sgn2_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else if (rounded[EXP_W+MAN_W] || rounded[EXP_W+MAN_W-1:MAN_W] == EXP_ONES) begin
      res_d = {sgn2_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      res_d = {sgn2_q, rounded[EXP_W+MAN_W-1:0]};
      inx_d = g | rest;
      unf_d = tiny & (g | rest);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      inv_q  <= 1'b0;
      inx_q  <= 1'b0;
    end else if (en) begin
      v1_q   <= valid_i;
      v2_q   <= v1_q;
      done_q <= v2_q;
      if (v2_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inv_q <= inv_d;
        inx_q <= inx_d;
      end
    end
  end

  // Datapath stages carry no reset; their valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (en && valid_i) begin
      sgn1_q     <= sgn1_d;
      eff1_q     <= eff1_d;
      zs1_q      <= zs1_d;
      spec1_q    <= spec1_d;
      nan1_q     <= nan1_d;
      exp1_q     <= exp1_d;
      dif1_q     <= dif1_d;
      sigL1_q    <= sigL1_d;
      sigS1_q    <= sigS1_d;
      specRes1_q <= specRes1_d;
    end
    if (en && v1_q) begin
      sgn2_q     <= sgn1_q;
      zs2_q      <= zs1_q;
      spec2_q    <= spec1_q;
      nan2_q     <= nan1_q;
      exp2_q     <= exp1_q;
      sum2_q     <= sum2_d;
      specRes2_q <= specRes1_q;
    end
  end
endmodule
